// File: rtl/payload_sender.sv
// rtl/payload_sender.sv - multi-message ROM payload streamer into the UART TX FIFO
// Optional trailing CR/LF per message when PAYLOAD_CRLF_EN is defined.
module payload_sender #(
  parameter int N_MSGS  = 4,
  parameter int MAX_LEN = 16,
  parameter int SEL_W   = $clog2(N_MSGS),
  parameter int ADDR_W  = $clog2(N_MSGS * MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  msg_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              tx_full,
  output logic              wr,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN);

`ifdef PAYLOAD_CRLF_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_DONE, S_CR, S_LF} state_t;
  localparam state_t S_MSG_END = S_CR;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;
  localparam state_t S_MSG_END = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              sel_ok;
  logic [ADDR_W-1:0] sel_base;

  assign sel_ok   = 32'(msg_sel) < N_MSGS;
  assign sel_base = ADDR_W'(32'(msg_sel) * MAX_LEN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wr      = 1'b0;
    w_data  = 8'h00;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && sel_ok) begin
          addr_d  = sel_base;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (rom_data == 8'h00) begin
          state_d = S_MSG_END;
        end else if (!tx_full) begin
          wr     = 1'b1;
          w_data = rom_data;
          idx_d  = idx_q + IDX_W'(1);
          // Address stays on the last byte at the cap so the next slot is never read.
          if (idx_d == LAST_IDX) begin
            state_d = S_MSG_END;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
`ifdef PAYLOAD_CRLF_EN
      S_CR: begin
        if (!tx_full) begin
          wr      = 1'b1;
          w_data  = 8'h0D;
          state_d = S_LF;
        end
      end
      S_LF: begin
        if (!tx_full) begin
          wr      = 1'b1;
          w_data  = 8'h0A;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr = addr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_payload_sender.sv
// tb/tb_payload_sender.sv - table-driven scoreboard bench for payload_sender
module tb_payload_sender;

  localparam int N_MSGS  = 4;
  localparam int MAX_LEN = 16;
  localparam int SEL_W   = 3;
  localparam int ADDR_W  = 6;
`ifdef PAYLOAD_CRLF_EN
  localparam int CRLF_N = 2;
`else
  localparam int CRLF_N = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [SEL_W-1:0]  msg_sel = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic              tx_full = 1'b0;
  logic              wr;
  logic [7:0]        w_data;
  logic              busy;
  logic              done;

  logic [7:0] rom [N_MSGS*MAX_LEN];
  logic [7:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  typedef struct {
    int sel;
    int stall_from;
    int stall_len;
    int mid_cyc;     // cycle of an extra start pulse; -1 none, -2 on the done cycle
    int exp_writes;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  payload_sender #(.N_MSGS(N_MSGS), .MAX_LEN(MAX_LEN), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_sel(msg_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_full(tx_full),
    .wr(wr), .w_data(w_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic run_vec(input vec_t v);
    int base = v.sel * MAX_LEN;
    int len = 0;
    int nwr = 0;
    int done_cyc = -1;
    int cyc = 1;
    int mid = (v.mid_cyc == -2) ? v.exp_done + CRLF_N : v.mid_cyc;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rom[base+i] == 8'h00) break;
      exp_q.push_back(rom[base+i]);
      len++;
    end
    if (CRLF_N != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    @(posedge clk); #1;
    start = 1'b1; msg_sel = SEL_W'(v.sel); tx_full = 1'b0;
    @(negedge clk);
    check("busy_c0", busy, 0);
    while (done_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      start   = (cyc == mid);
      msg_sel = (cyc == mid) ? SEL_W'((v.sel + 1) % N_MSGS) : SEL_W'(v.sel);
      tx_full = (v.stall_from >= 0 && cyc >= v.stall_from && cyc < v.stall_from + v.stall_len);
      @(negedge clk);
      if (wr) begin
        if (exp_q.size() == 0) check("unexpected_wr", w_data, 32'hFFFF_FFFF);
        else check("w_data", w_data, exp_q.pop_front());
        if (nwr < len) check("rom_addr_wr", rom_addr, base + nwr);
        nwr++;
      end else begin
        check("w_data_idle", w_data, 0);
      end
      check("busy", busy, 1);
      if (done) done_cyc = cyc;
      cyc++;
    end
    check("done_cycle", done_cyc, v.exp_done + CRLF_N);
    check("write_count", nwr, v.exp_writes + CRLF_N);
    check("rom_addr_end", rom_addr, base + ((len < MAX_LEN) ? len : MAX_LEN - 1));
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    if (v.mid_cyc == -2) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("start_at_done_busy", busy, 0);
      check("start_at_done_wr", wr, 0);
    end
  endtask

  initial begin
    for (int s = 0; s < N_MSGS; s++)
      for (int i = 0; i < MAX_LEN; i++) rom[s*MAX_LEN+i] = 8'h7E;
    for (int i = 0; i < MAX_LEN; i++) rom[i] = 8'h41 + 8'(i);
    rom[16] = 8'h48; rom[17] = 8'h49; rom[18] = 8'h00;
    rom[32] = 8'h41; rom[33] = 8'h42; rom[34] = 8'h43; rom[35] = 8'h00;
    rom[48] = 8'h00;

    vecs[0] = '{1, -1, 0, -1,  2,  7};
    vecs[1] = '{1,  2, 4, -1,  2, 11};
    vecs[2] = '{0, -1, 0, -1, 16, 33};
    vecs[3] = '{2, -1, 0,  3,  3,  9};
    vecs[4] = '{3, -1, 0, -1,  0,  3};
    vecs[5] = '{2,  4, 1,  7,  3, 10};
    vecs[6] = '{1, -1, 0, -2,  2,  7};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_wr", wr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    @(posedge clk); #1;
    start = 1'b1; msg_sel = 3'd5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bad_sel_busy", busy, 0);
      check("bad_sel_wr", wr, 0);
      @(posedge clk); #1;
      start = 1'b0;
    end

    begin
      int nwr = 0;
      int cyc = 0;
      start = 1'b1; msg_sel = 3'd0;
      while (nwr < 3 && cyc < 50) begin
        @(negedge clk);
        if (wr) nwr++;
        cyc++;
        if (nwr < 3) begin
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      check("mid_reset_writes_seen", nwr, 3);
      reset_n = 1'b0;
      #1;
      check("mid_rst_rom_addr", rom_addr, 0);
      check("mid_rst_wr", wr, 0);
      check("mid_rst_w_data", w_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      repeat (2) begin
        @(negedge clk);
        check("in_rst_wr", wr, 0);
        check("in_rst_done", done, 0);
      end
      reset_n = 1'b1;
    end
    run_vec(vecs[2]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
